// File: rtl/lsu_pkg.sv
// Shared types and RV32I size/sign encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, extension for loads, and legality check of
// the incoming op. Purely combinational.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BE_W  = WIDTH / 8
) (
  input  logic             is_store,
  input  logic [2:0]       st_funct3,
  input  logic [1:0]       st_off,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] lane_data,
  output logic [BE_W-1:0]  lane_be,
  output logic             illegal,
  input  logic [2:0]       ld_funct3,
  input  logic [1:0]       ld_off,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    lane_data = wdata;
    lane_be   = '0;
    illegal   = 1'b0;
    case (st_funct3)
      F3_B: begin
        lane_data = {4{wdata[7:0]}};
        lane_be   = 4'b0001 << st_off;
      end
      F3_H: begin
        lane_data = {2{wdata[15:0]}};
        lane_be   = 4'b0011 << st_off;
        illegal   = st_off[0];
      end
      F3_W: begin
        lane_be = 4'b1111;
        illegal = (st_off != 2'b00);
      end
      // Unsigned variants only make sense for loads.
      F3_BU:   illegal = is_store;
      F3_HU:   illegal = is_store | st_off[0];
      default: illegal = 1'b1;
    endcase
    if (!is_store) lane_be = '0;
  end

  always_comb begin
    byte_sel = rdata[{ld_off, 3'b000} +: 8];
    half_sel = ld_off[1] ? rdata[31:16] : rdata[15:0];
    case (ld_funct3)
      F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   ld_data = {24'b0, byte_sel};
      F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   ld_data = {16'b0, half_sel};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one load or store at a time over a req/ready data port,
// stalling the core while the access is outstanding.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BE_W  = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_load,
  input  logic             ex_store,
  input  logic [2:0]       ex_funct3,
  input  logic [WIDTH-1:0] ex_addr,
  input  logic [WIDTH-1:0] ex_wdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [BE_W-1:0]  mem_be,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy,
  output logic             wb_valid,
  output logic [WIDTH-1:0] wb_data,
  output logic             fault
);

  lsu_state_t       state_q, state_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]  mem_be_q, mem_be_d;
  logic [2:0]       ld_funct3_q, ld_funct3_d;
  logic [1:0]       ld_off_q, ld_off_d;
  logic [WIDTH-1:0] wb_data_q, wb_data_d;
  logic             fault_q, fault_d;

  logic [WIDTH-1:0] lane_data, ld_data;
  logic [BE_W-1:0]  lane_be;
  logic             illegal;

  lsu_align #(.WIDTH(WIDTH), .BE_W(BE_W)) u_align (
    .is_store  (ex_store),
    .st_funct3 (ex_funct3),
    .st_off    (ex_addr[1:0]),
    .wdata     (ex_wdata),
    .lane_data (lane_data),
    .lane_be   (lane_be),
    .illegal   (illegal),
    .ld_funct3 (ld_funct3_q),
    .ld_off    (ld_off_q),
    .rdata     (mem_rdata),
    .ld_data   (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    ld_funct3_d = ld_funct3_q;
    ld_off_d    = ld_off_q;
    wb_data_d   = wb_data_q;
    fault_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_valid && (ex_load || ex_store)) begin
          if (illegal || (ex_load && ex_store)) begin
            fault_d = 1'b1;
          end else begin
            state_d     = REQ;
            mem_we_d    = ex_store;
            mem_addr_d  = {ex_addr[WIDTH-1:2], 2'b00};
            mem_wdata_d = lane_data;
            mem_be_d    = lane_be;
            ld_funct3_d = ex_funct3;
            ld_off_d    = ex_addr[1:0];
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          if (mem_we_q) begin
            state_d = IDLE;
          end else begin
            wb_data_d = ld_data;
            state_d   = RESP;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      ld_funct3_q <= '0;
      ld_off_q    <= '0;
      wb_data_q   <= '0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      ld_funct3_q <= ld_funct3_d;
      ld_off_q    <= ld_off_d;
      wb_data_q   <= wb_data_d;
      fault_q     <= fault_d;
    end
  end

  assign mem_req   = (state_q == REQ);
  assign busy      = (state_q != IDLE);
  assign wb_valid  = (state_q == RESP);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign wb_data   = wb_data_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Vector table plus scoreboard bench for load_store_unit.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        busy, wb_valid, fault;
  logic [31:0] wb_data;

  load_store_unit dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .busy(busy), .wb_valid(wb_valid),
    .wb_data(wb_data), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] last_wb = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } memx_t;

  memx_t       exp_mem[$];
  logic [31:0] exp_wb[$];
  memx_t       e;

  // Scoreboard: memory requests and writeback results against expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req) begin
        if (exp_mem.size() == 0) begin
          check("unexpected_mem_req", {31'b0, mem_req}, 32'd0);
        end else begin
          e = exp_mem[0];
          check("mem_we", {31'b0, mem_we}, {31'b0, e.we});
          check("mem_addr", mem_addr, e.addr);
          check("mem_be", {28'b0, mem_be}, {28'b0, e.be});
          if (e.we) check("mem_wdata", mem_wdata, e.wdata);
          if (mem_ready) void'(exp_mem.pop_front());
        end
      end
      if (wb_valid) begin
        if (exp_wb.size() == 0) check("unexpected_wb_valid", {31'b0, wb_valid}, 32'd0);
        else check("wb_data", wb_data, exp_wb.pop_front());
      end
    end
  end

  typedef struct {
    string       name;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        flt;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t vecs[15];

  task automatic check_zero(input string tag);
    check({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
    check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_mem_be"}, {28'b0, mem_be}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_wb_valid"}, {31'b0, wb_valid}, 32'd0);
    check({tag, "_wb_data"}, wb_data, 32'd0);
    check({tag, "_fault"}, {31'b0, fault}, 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    memx_t m;
    @(posedge clk); #1;
    ex_valid  = 1'b1;
    ex_load   = v.ld;
    ex_store  = v.st;
    ex_funct3 = v.f3;
    ex_addr   = v.addr;
    ex_wdata  = v.wdata;
    mem_rdata = v.rdata;
    mem_ready = (v.waits == 0);
    if (!v.flt) begin
      m.we    = v.st;
      m.addr  = {v.addr[31:2], 2'b00};
      m.wdata = v.exp_wdata;
      m.be    = v.st ? v.exp_be : 4'b0000;
      exp_mem.push_back(m);
      if (v.ld) exp_wb.push_back(v.exp_wb);
    end
    @(posedge clk); #1;
    if (v.flt) begin
      ex_valid = 1'b0;
      check({v.name, "_fault"}, {31'b0, fault}, 32'd1);
      check({v.name, "_busy"}, {31'b0, busy}, 32'd0);
      check({v.name, "_mem_req"}, {31'b0, mem_req}, 32'd0);
      @(posedge clk); #1;
      check({v.name, "_fault_pulse"}, {31'b0, fault}, 32'd0);
    end else begin
      // EX keeps presenting the op while stalled; the unit must ignore it.
      check({v.name, "_busy_acc"}, {31'b0, busy}, 32'd1);
      check({v.name, "_no_fault"}, {31'b0, fault}, 32'd0);
      for (int k = 1; k <= v.waits; k++) begin
        @(posedge clk); #1;
        if (k == v.waits) mem_ready = 1'b1;
      end
      check({v.name, "_mem_req"}, {31'b0, mem_req}, 32'd1);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      if (v.ld) begin
        check({v.name, "_wb_valid"}, {31'b0, wb_valid}, 32'd1);
        check({v.name, "_busy_resp"}, {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        check({v.name, "_busy_end"}, {31'b0, busy}, 32'd0);
        check({v.name, "_wb_pulse"}, {31'b0, wb_valid}, 32'd0);
        last_wb = v.exp_wb;
      end else begin
        ex_valid = 1'b0;
        check({v.name, "_busy_end"}, {31'b0, busy}, 32'd0);
        check({v.name, "_no_wb"}, {31'b0, wb_valid}, 32'd0);
        check({v.name, "_wb_hold"}, wb_data, last_wb);
      end
    end
  endtask

  initial begin
    vecs[0]  = '{"sw",        0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 32'hDEADBEEF, 4'b1111, 32'h0};
    vecs[1]  = '{"lb",        1, 0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 0, 0, 32'h0,        4'b0000, 32'hFFFFFF80};
    vecs[2]  = '{"lbu",       1, 0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0, 0, 32'h0,        4'b0000, 32'h00000080};
    vecs[3]  = '{"sh",        0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        0, 0, 32'hABCDABCD, 4'b1100, 32'h0};
    vecs[4]  = '{"lw_mis",    1, 0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0};
    vecs[5]  = '{"ld_f3_011", 1, 0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0};
    vecs[6]  = '{"st_f3_100", 0, 1, 3'b100, 32'h100, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0};
    vecs[7]  = '{"ld_and_st", 1, 1, 3'b010, 32'h100, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0};
    vecs[8]  = '{"lh_wait3",  1, 0, 3'b001, 32'h002, 32'h0,        32'h7FFF0000, 3, 0, 32'h0,        4'b0000, 32'h00007FFF};
    vecs[9]  = '{"sb_wait1",  0, 1, 3'b000, 32'h001, 32'h00000055, 32'h0,        1, 0, 32'h55555555, 4'b0010, 32'h0};
    vecs[10] = '{"lh_neg",    1, 0, 3'b001, 32'h000, 32'h0,        32'h12348001, 0, 0, 32'h0,        4'b0000, 32'hFFFF8001};
    vecs[11] = '{"lhu",       1, 0, 3'b101, 32'h000, 32'h0,        32'h12348001, 0, 0, 32'h0,        4'b0000, 32'h00008001};
    vecs[12] = '{"lw_wait2",  1, 0, 3'b010, 32'h104, 32'h0,        32'hCAFEF00D, 2, 0, 32'h0,        4'b0000, 32'hCAFEF00D};
    vecs[13] = '{"sh_mis",    0, 1, 3'b001, 32'h201, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0};
    vecs[14] = '{"lhu_mis",   1, 0, 3'b101, 32'h003, 32'h0,        32'h0,        0, 1, 32'h0,        4'b0000, 32'h0};

    rst = 1'b1;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    ex_funct3 = 3'b000; ex_addr = 32'h0; ex_wdata = 32'h0;
    mem_ready = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset in the middle of a load; a late mem_ready must be ignored.
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0;
    ex_funct3 = 3'b010; ex_addr = 32'h300; mem_ready = 1'b0;
    e.we = 1'b0; e.addr = 32'h300; e.wdata = 32'h0; e.be = 4'b0000;
    exp_mem.push_back(e);
    @(posedge clk); #1;
    check("rst_mid_req", {31'b0, mem_req}, 32'd1);
    ex_valid = 1'b0; ex_load = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_mem.delete();
    mem_ready = 1'b1; mem_rdata = 32'h11223344;
    check_zero("rst_mid");
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("rst_late_req", {31'b0, mem_req}, 32'd0);
    check("rst_late_busy", {31'b0, busy}, 32'd0);
    check("rst_late_wb", {31'b0, wb_valid}, 32'd0);
    last_wb = 32'h0;
    run_vec(vecs[0]);

    repeat (2) @(posedge clk);
    #1;
    check("mem_queue_drained", exp_mem.size(), 32'd0);
    check("wb_queue_drained", exp_wb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
